// File: rtl/rvfi_causal_window_check.sv
// Causality checker for one writer instruction on the RVFI retirement bus: flags later-ordered
// readers of its destination and excessive reordering. Memory causality under RISCV_FORMAL_CAUSAL_MEM_EN.
module rvfi_causal_window_check #(
    parameter int NRET        = 1,
    parameter int CHANNEL_IDX = 0,
    parameter int MAX_REORDER = 8,
    parameter int XLEN        = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     check,
    input  logic [63:0]              tgt_order,
    input  logic [4:0]               tgt_reg,
    input  logic [NRET-1:0]          rvfi_valid,
    input  logic [64*NRET-1:0]       rvfi_order,
    input  logic [5*NRET-1:0]        rvfi_rs1_addr,
    input  logic [5*NRET-1:0]        rvfi_rs2_addr,
    input  logic [5*NRET-1:0]        rvfi_rd_addr,
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
    input  logic [XLEN*NRET-1:0]     rvfi_mem_addr,
    input  logic [XLEN/8*NRET-1:0]   rvfi_mem_rmask,
    input  logic [XLEN/8*NRET-1:0]   rvfi_mem_wmask,
    input  logic [XLEN-1:0]          tgt_mem_addr,
    output logic                     mem_fail,
`endif
    output logic                     done,
    output logic                     causal_fail,
    output logic                     reorder_fail,
    output logic [7:0]               reorder_cnt
);

    // state    | meaning
    // ST_WATCH | counting later retirements, waiting for the writer
    // ST_DONE  | writer accepted, verdicts frozen until reset
    typedef enum logic {ST_WATCH, ST_DONE} state_t;

    // One extra bit so MAX_REORDER=255 can still saturate at 256.
    localparam int CW = 9;
    localparam logic [CW-1:0] SAT = CW'(MAX_REORDER + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_REORDER);

    state_t          state;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_next;
    logic [CW:0]     cnt_sum;
    logic            pend_q;
    logic            pend_next;
    logic [NRET-1:0] later;
    logic            any_reader;
    logic            qualified;
    logic            unused_rd;

    always_comb begin
        later      = '0;
        any_reader = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            later[c] = rvfi_valid[c] && (rvfi_order[64*c +: 64] > tgt_order);
            if (later[c] && tgt_reg != 5'd0 &&
                (rvfi_rs1_addr[5*c +: 5] == tgt_reg || rvfi_rs2_addr[5*c +: 5] == tgt_reg))
                any_reader = 1'b1;
        end
    end

    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int c = 0; c < NRET; c++)
            if (later[c])
                cnt_sum = cnt_sum + (CW+1)'(1);
        cnt_next = (cnt_sum >= {1'b0, SAT}) ? SAT : cnt_sum[CW-1:0];
    end

    assign pend_next = pend_q | any_reader;

    assign qualified = check && rvfi_valid[CHANNEL_IDX]
                    && rvfi_rd_addr[5*CHANNEL_IDX +: 5] == tgt_reg
                    && rvfi_order[64*CHANNEL_IDX +: 64] == tgt_order
                    && tgt_reg != 5'd0;

    assign unused_rd = ^rvfi_rd_addr;

    assign reorder_cnt = cnt_q[CW-1] ? 8'hFF : cnt_q[7:0];

`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
    // Loads compare at word granularity: byte-offset bits are ignored.
    localparam int LSB = $clog2(XLEN/8);
    localparam logic [XLEN-1:0] ADDR_MASK = {XLEN{1'b1}} << LSB;

    logic pend_mem_q;
    logic pend_mem_next;
    logic mem_hit;
    logic writer_store;
    logic unused_wmask;

    always_comb begin
        mem_hit = 1'b0;
        for (int c = 0; c < NRET; c++)
            if (later[c] && rvfi_mem_rmask[c*(XLEN/8) +: XLEN/8] != '0 &&
                (rvfi_mem_addr[c*XLEN +: XLEN] & ADDR_MASK) == (tgt_mem_addr & ADDR_MASK))
                mem_hit = 1'b1;
    end

    assign pend_mem_next = pend_mem_q | mem_hit;
    assign writer_store  = rvfi_mem_wmask[CHANNEL_IDX*(XLEN/8) +: XLEN/8] != '0;
    assign unused_wmask  = ^rvfi_mem_wmask;
`else
    localparam int unused_xlen = XLEN;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_WATCH;
            done         <= 1'b0;
            causal_fail  <= 1'b0;
            reorder_fail <= 1'b0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
            pend_mem_q   <= 1'b0;
            mem_fail     <= 1'b0;
`endif
        end else if (state == ST_WATCH) begin
            cnt_q  <= cnt_next;
            pend_q <= pend_next;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
            pend_mem_q <= pend_mem_next;
`endif
            if (qualified) begin
                state        <= ST_DONE;
                done         <= 1'b1;
                causal_fail  <= pend_next;
                reorder_fail <= cnt_next > LIMIT;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
                mem_fail     <= pend_mem_next && writer_store;
`endif
            end
        end
    end

`ifdef FORMAL
    logic past_qual;

    always_ff @(posedge clock) begin
        if (reset)
            past_qual <= 1'b0;
        else
            past_qual <= (state == ST_WATCH) && qualified;
    end

    always_comb begin
        assume (tgt_reg != 5'd0);
        if (check)
            assume (qualified);
        if (past_qual) begin
            assert (!causal_fail);
            assert (!reorder_fail);
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
            assert (!mem_fail);
`endif
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_causal_window_check.sv
// Directed and randomized bench for rvfi_causal_window_check; expectations come from a
// retirement-history model. Memory checks are built when RISCV_FORMAL_CAUSAL_MEM_EN is defined.
module tb_rvfi_causal_window_check;
    localparam int NRET = 2;
    localparam int MAXR = 2;
    localparam int XLEN = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 check;
    logic [63:0]          tgt_order;
    logic [4:0]           tgt_reg;
    logic [NRET-1:0]      rvfi_valid;
    logic [64*NRET-1:0]   rvfi_order;
    logic [5*NRET-1:0]    rvfi_rs1_addr;
    logic [5*NRET-1:0]    rvfi_rs2_addr;
    logic [5*NRET-1:0]    rvfi_rd_addr;
    logic                 done;
    logic                 causal_fail;
    logic                 reorder_fail;
    logic [7:0]           reorder_cnt;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
    logic [XLEN*NRET-1:0]   rvfi_mem_addr;
    logic [XLEN/8*NRET-1:0] rvfi_mem_rmask;
    logic [XLEN/8*NRET-1:0] rvfi_mem_wmask;
    logic [XLEN-1:0]        tgt_mem_addr;
    logic                   mem_fail;
`endif

    rvfi_causal_window_check #(
        .NRET(NRET), .CHANNEL_IDX(0), .MAX_REORDER(MAXR), .XLEN(XLEN)
    ) dut (
        .clock(clock), .reset(reset), .check(check),
        .tgt_order(tgt_order), .tgt_reg(tgt_reg),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .tgt_mem_addr(tgt_mem_addr), .mem_fail(mem_fail),
`endif
        .done(done), .causal_fail(causal_fail), .reorder_fail(reorder_fail),
        .reorder_cnt(reorder_cnt)
    );

    always #5 clock = ~clock;

    // Every retirement seen since reset (until the writer is accepted).
    typedef struct {
        logic [63:0] order;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          load;
        logic [31:0] addr;
    } ret_t;

    ret_t  hist[$];
    bit    m_done, m_cf, m_rf, m_mf;
    int    n_cmp = 0;
    int    n_err = 0;
    string scen = "init";

    function automatic int later_count();
        int n = 0;
        foreach (hist[i])
            if (hist[i].order > tgt_order) n++;
        return n;
    endfunction

    task automatic model_step();
        ret_t r;
        if (reset) begin
            hist.delete();
            m_done = 0; m_cf = 0; m_rf = 0; m_mf = 0;
        end else if (!m_done) begin
            for (int c = 0; c < NRET; c++) begin
                if (rvfi_valid[c]) begin
                    r.order = rvfi_order[64*c +: 64];
                    r.rs1   = rvfi_rs1_addr[5*c +: 5];
                    r.rs2   = rvfi_rs2_addr[5*c +: 5];
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
                    r.load  = rvfi_mem_rmask[4*c +: 4] != 4'd0;
                    r.addr  = rvfi_mem_addr[32*c +: 32];
`else
                    r.load  = 0;
                    r.addr  = '0;
`endif
                    hist.push_back(r);
                end
            end
            if (check && rvfi_valid[0] && rvfi_rd_addr[4:0] == tgt_reg &&
                rvfi_order[63:0] == tgt_order && tgt_reg != 0) begin
                m_done = 1;
                m_cf = 0;
                m_mf = 0;
                foreach (hist[i]) begin
                    if (hist[i].order > tgt_order && (hist[i].rs1 == tgt_reg || hist[i].rs2 == tgt_reg))
                        m_cf = 1;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
                    if (hist[i].order > tgt_order && hist[i].load &&
                        hist[i].addr[31:2] == tgt_mem_addr[31:2] && rvfi_mem_wmask[3:0] != 4'd0)
                        m_mf = 1;
`endif
                end
                m_rf = later_count() > MAXR;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0h expected=%0h", scen, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int lc = later_count();
        chk("done", done, m_done);
        chk("causal_fail", causal_fail, m_cf);
        chk("reorder_fail", reorder_fail, m_rf);
        chk("reorder_cnt", reorder_cnt, (lc > MAXR) ? MAXR + 1 : lc);
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
        chk("mem_fail", mem_fail, m_mf);
`endif
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        check = 0;
        rvfi_valid = '0;
        rvfi_order = '0;
        rvfi_rs1_addr = '0;
        rvfi_rs2_addr = '0;
        rvfi_rd_addr = '0;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
        rvfi_mem_addr = '0;
        rvfi_mem_rmask = '0;
        rvfi_mem_wmask = '0;
`endif
    endtask

    task automatic set_ch(input int c, input logic [63:0] ord, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        rvfi_valid[c] = 1'b1;
        rvfi_order[64*c +: 64] = ord;
        rvfi_rs1_addr[5*c +: 5] = rs1;
        rvfi_rs2_addr[5*c +: 5] = rs2;
        rvfi_rd_addr[5*c +: 5] = rd;
    endtask

    task automatic reset_dut();
        idle();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        tgt_order = 64'd10;
        tgt_reg = 5'd5;
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
        tgt_mem_addr = 32'h0000_1000;
`endif
        scen = "reset";
        reset_dut();
        chk("rst_done", done, 0);
        chk("rst_cnt", reorder_cnt, 0);

        scen = "in_order";
        set_ch(0, 9, 1, 2, 3); cyc();
        idle(); set_ch(0, 10, 1, 2, 5); check = 1; cyc();
        chk("ex_done", done, 1);
        chk("ex_cf", causal_fail, 0);
        chk("ex_cnt", reorder_cnt, 0);
        idle(); set_ch(1, 20, 5, 5, 1); check = 1; cyc();
        chk("hold_cf", causal_fail, 0);

        scen = "early_reader";
        reset_dut();
        set_ch(1, 12, 0, 5, 7); cyc();
        idle(); cyc();
        set_ch(0, 10, 1, 2, 5); check = 1; cyc();
        chk("ex_cf", causal_fail, 1);
        chk("ex_cnt", reorder_cnt, 1);

        scen = "same_cycle";
        reset_dut();
        set_ch(0, 10, 1, 2, 5); set_ch(1, 11, 5, 0, 8); check = 1; cyc();
        chk("ex_cf", causal_fail, 1);
        chk("ex_done", done, 1);

        scen = "reorder";
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            idle(); set_ch(1, 64'(11 + k), 1, 2, 3); cyc();
        end
        chk("sat_cnt", reorder_cnt, 3);
        idle(); set_ch(0, 10, 1, 2, 5); check = 1; cyc();
        chk("ex_rf", reorder_fail, 1);
        chk("ex_cf", causal_fail, 0);
        chk("ex_cnt", reorder_cnt, 3);

        scen = "unqualified";
        reset_dut();
        set_ch(0, 10, 1, 2, 6); check = 1; cyc();
        chk("ex_done", done, 0);
        idle(); set_ch(1, 11, 5, 0, 1); cyc();
        idle(); set_ch(0, 10, 1, 2, 5); check = 1; reset = 1; cyc();
        reset = 0;
        chk("rst_done", done, 0);
        chk("rst_cf", causal_fail, 0);
        chk("rst_cnt", reorder_cnt, 0);

        scen = "reg_zero";
        tgt_reg = 5'd0;
        idle(); set_ch(0, 10, 0, 0, 0); set_ch(1, 11, 0, 0, 0); check = 1; cyc();
        chk("ex_done", done, 0);
        chk("ex_cf", causal_fail, 0);
        tgt_reg = 5'd5;

`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
        scen = "mem_store";
        reset_dut();
        set_ch(1, 11, 1, 2, 3); rvfi_mem_rmask[7:4] = 4'hF; rvfi_mem_addr[63:32] = tgt_mem_addr + 1; cyc();
        idle(); set_ch(0, 10, 1, 2, 5); rvfi_mem_wmask[3:0] = 4'hF; check = 1; cyc();
        chk("ex_mf", mem_fail, 1);

        scen = "mem_nostore";
        reset_dut();
        set_ch(1, 11, 1, 2, 3); rvfi_mem_rmask[7:4] = 4'hF; rvfi_mem_addr[63:32] = tgt_mem_addr + 1; cyc();
        idle(); set_ch(0, 10, 1, 2, 5); check = 1; cyc();
        chk("ex_mf", mem_fail, 0);
`endif

        scen = "random";
        for (int run = 0; run < 30; run++) begin
            tgt_order = 64'(8 + $urandom_range(0, 1000));
            tgt_reg = 5'($urandom_range(0, 7));
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
            tgt_mem_addr = $urandom & 32'hFFFF_FFF0;
`endif
            reset_dut();
            for (int k = 0; k < 20; k++) begin
                idle();
                for (int c = 0; c < NRET; c++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_ch(c, tgt_order - 3 + 64'($urandom_range(0, 6)),
                               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)));
`ifdef RISCV_FORMAL_CAUSAL_MEM_EN
                        rvfi_mem_addr[32*c +: 32] = tgt_mem_addr ^ 32'($urandom_range(0, 7));
                        rvfi_mem_rmask[4*c +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
                        rvfi_mem_wmask[4*c +: 4] = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'h0;
`endif
                    end
                end
                if ($urandom_range(0, 2) == 0) rvfi_order[63:0] = tgt_order;
                if ($urandom_range(0, 1) == 0) rvfi_rd_addr[4:0] = tgt_reg;
                check = ($urandom_range(0, 3) == 0);
                reset = ($urandom_range(0, 29) == 0);
                cyc();
                reset = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
